// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/fetch stage: drives instruction memory, captures IR, resolves BR locally
module fetch_unit #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] PC_RESET   = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_target_i,
  output logic [31:0] im_addr_o,
  output logic        im_read_o,
  input  logic [31:0] im_data_i,
  output logic [31:0] ir_o,
  output logic [31:0] ir_pc_o,
  output logic        ir_valid_o,
  output logic        halt_o,
  output logic        pc_oob_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  localparam logic [31:0] DEPTH32   = 32'(IMEM_DEPTH);
  localparam logic [5:0]  OPC_BR    = 6'b110000;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;

  logic        pc_in_range;
  logic        flush_in_range;
  logic        is_br;
  logic        is_self_loop;
  logic [31:0] br_off;
  logic [31:0] pc_seq;

  // Range checks and branch decode of the word currently returned by memory
  always_comb begin
    pc_in_range    = (pc_q < DEPTH32);
    flush_in_range = (flush_target_i < DEPTH32);
    is_br          = (im_data_i[31:26] == OPC_BR);
    is_self_loop   = &im_data_i[25:0];
    br_off         = {{6{im_data_i[25]}}, im_data_i[25:0]};
    pc_seq         = pc_q + 32'd1;
  end

  // Next-state logic: flush beats stall beats normal fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    if (flush_i) begin
      // Redirect from execute; IR contents are kept but marked dead
      pc_d       = flush_target_i;
      ir_valid_d = 1'b0;
      state_d    = flush_in_range ? ST_RUN : ST_ERROR;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!pc_in_range) begin
            // A previous redirect left the PC outside memory: no fetch
            state_d    = ST_ERROR;
            ir_valid_d = 1'b0;
          end else if (!stall_i) begin
            // im_data_i is only consumed here, where im_read_o is high
            ir_d       = im_data_i;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            if (is_br && is_self_loop) begin
              state_d = ST_HALT;
            end else if (is_br) begin
              pc_d = pc_seq + br_off;
            end else begin
              pc_d = pc_seq;
            end
          end
        end
        ST_HALT: begin
          if (!stall_i) begin
            ir_valid_d = 1'b0;
          end
        end
        ST_ERROR: begin
          ir_valid_d = 1'b0;
        end
        default: begin
          state_d    = ST_ERROR;
          ir_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= PC_RESET;
      ir_q       <= 32'd0;
      ir_pc_q    <= 32'd0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign im_addr_o  = pc_q;
  assign im_read_o  = (state_q == ST_RUN) && pc_in_range;
  assign ir_o       = ir_q;
  assign ir_pc_o    = ir_pc_q;
  assign ir_valid_o = ir_valid_q;
  assign halt_o     = (state_q == ST_HALT);
  assign pc_oob_o   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_target_i;
  logic [31:0] im_addr_o;
  logic        im_read_o;
  logic [31:0] im_data_i;
  logic [31:0] ir_o;
  logic [31:0] ir_pc_o;
  logic        ir_valid_o;
  logic        halt_o;
  logic        pc_oob_o;

  logic [31:0] mem [0:255];
  int n_checks;
  int n_fail;

  fetch_unit #(.IMEM_DEPTH(256), .PC_RESET(32'd0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .flush_target_i (flush_target_i),
    .im_addr_o      (im_addr_o),
    .im_read_o      (im_read_o),
    .im_data_i      (im_data_i),
    .ir_o           (ir_o),
    .ir_pc_o        (ir_pc_o),
    .ir_valid_o     (ir_valid_o),
    .halt_o         (halt_o),
    .pc_oob_o       (pc_oob_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data only meaningful while read is enabled
  assign im_data_i = im_read_o ? mem[im_addr_o[7:0]] : 32'hxxxx_xxxx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ir(input string tag, input logic [31:0] e_ir, input logic [31:0] e_pc,
                        input logic e_v, input logic [31:0] e_addr);
    chk({tag, ".ir"}, ir_o, e_ir);
    chk({tag, ".ir_pc"}, ir_pc_o, e_pc);
    chk({tag, ".ir_valid"}, {31'd0, ir_valid_o}, {31'd0, e_v});
    chk({tag, ".im_addr"}, im_addr_o, e_addr);
  endtask

  task automatic chk_st(input string tag, input logic e_read, input logic e_halt, input logic e_oob);
    chk({tag, ".im_read"}, {31'd0, im_read_o}, {31'd0, e_read});
    chk({tag, ".halt"}, {31'd0, halt_o}, {31'd0, e_halt});
    chk({tag, ".pc_oob"}, {31'd0, pc_oob_o}, {31'd0, e_oob});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    mem[0]  = 32'h0111_0002;
    mem[4]  = 32'hC3FF_FFFB;   // BR -5 -> 0
    mem[8]  = 32'hC3FF_FFFF;   // BR -1 -> halt
    mem[12] = 32'hC000_012C;   // BR +300 -> 313
    mem[13] = 32'hC3FF_FFF1;   // BR -15 -> 0xFFFFFFFF

    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_target_i = 32'd0;
    tick;
    chk_ir("reset", 32'd0, 32'd0, 1'b0, 32'd0);
    chk_st("reset", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;

    tick; chk_ir("f0", 32'h0111_0002, 32'd0, 1'b1, 32'd1);
    tick; chk_ir("f1", 32'h1000_0001, 32'd1, 1'b1, 32'd2);
    tick; chk_ir("f2", 32'h1000_0002, 32'd2, 1'b1, 32'd3);
    tick; chk_ir("f3", 32'h1000_0003, 32'd3, 1'b1, 32'd4);
    tick; chk_ir("br_back", 32'hC3FF_FFFB, 32'd4, 1'b1, 32'd0);
    tick; chk_ir("br_nobubble", 32'h0111_0002, 32'd0, 1'b1, 32'd1);

    flush_i = 1'b1; flush_target_i = 32'd8;
    tick; chk_ir("flush8", 32'h0111_0002, 32'd0, 1'b0, 32'd8);
    chk_st("flush8", 1'b1, 1'b0, 1'b0);
    flush_i = 1'b0;
    tick; chk_ir("self_loop", 32'hC3FF_FFFF, 32'd8, 1'b1, 32'd8);
    chk_st("self_loop", 1'b0, 1'b1, 1'b0);
    tick; chk_ir("halted", 32'hC3FF_FFFF, 32'd8, 1'b0, 32'd8);
    chk_st("halted", 1'b0, 1'b1, 1'b0);
    tick; chk_ir("halted2", 32'hC3FF_FFFF, 32'd8, 1'b0, 32'd8);
    chk_st("halted2", 1'b0, 1'b1, 1'b0);

    flush_i = 1'b1; flush_target_i = 32'd2;
    tick; chk_ir("halt_exit", 32'hC3FF_FFFF, 32'd8, 1'b0, 32'd2);
    chk_st("halt_exit", 1'b1, 1'b0, 1'b0);
    flush_i = 1'b0;
    tick; chk_ir("after_halt", 32'h1000_0002, 32'd2, 1'b1, 32'd3);

    flush_i = 1'b1; flush_target_i = 32'd5;
    tick; chk_ir("flush5", 32'h1000_0002, 32'd2, 1'b0, 32'd5);
    flush_i = 1'b0; stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick; chk_ir("stall", 32'h1000_0002, 32'd2, 1'b0, 32'd5);
      chk_st("stall", 1'b1, 1'b0, 1'b0);
    end
    flush_i = 1'b1; flush_target_i = 32'd1;
    tick; chk_ir("flush_over_stall", 32'h1000_0002, 32'd2, 1'b0, 32'd1);
    flush_i = 1'b0; stall_i = 1'b0;
    tick; chk_ir("fetch1", 32'h1000_0001, 32'd1, 1'b1, 32'd2);
    stall_i = 1'b1;
    tick; chk_ir("stall_valid", 32'h1000_0001, 32'd1, 1'b1, 32'd2);
    stall_i = 1'b0;
    tick; chk_ir("unstall", 32'h1000_0002, 32'd2, 1'b1, 32'd3);

    flush_i = 1'b1; flush_target_i = 32'd300;
    tick; chk_ir("flush300", 32'h1000_0002, 32'd2, 1'b0, 32'd300);
    chk_st("flush300", 1'b0, 1'b0, 1'b1);
    flush_i = 1'b0;
    tick; chk_ir("err_hold", 32'h1000_0002, 32'd2, 1'b0, 32'd300);
    chk_st("err_hold", 1'b0, 1'b0, 1'b1);
    flush_i = 1'b1; flush_target_i = 32'd0;
    tick; chk_ir("err_exit", 32'h1000_0002, 32'd2, 1'b0, 32'd0);
    chk_st("err_exit", 1'b1, 1'b0, 1'b0);
    flush_i = 1'b0;
    tick; chk_ir("recover", 32'h0111_0002, 32'd0, 1'b1, 32'd1);

    flush_i = 1'b1; flush_target_i = 32'd12;
    tick; chk_ir("flush12", 32'h0111_0002, 32'd0, 1'b0, 32'd12);
    flush_i = 1'b0;
    tick; chk_ir("br_far", 32'hC000_012C, 32'd12, 1'b1, 32'd313);
    chk_st("br_far", 1'b0, 1'b0, 1'b0);
    tick; chk_ir("br_far_err", 32'hC000_012C, 32'd12, 1'b0, 32'd313);
    chk_st("br_far_err", 1'b0, 1'b0, 1'b1);

    flush_i = 1'b1; flush_target_i = 32'd13;
    tick; chk_ir("flush13", 32'hC000_012C, 32'd12, 1'b0, 32'd13);
    chk_st("flush13", 1'b1, 1'b0, 1'b0);
    flush_i = 1'b0;
    tick; chk_ir("br_wrap", 32'hC3FF_FFF1, 32'd13, 1'b1, 32'hFFFF_FFFF);
    chk_st("br_wrap", 1'b0, 1'b0, 1'b0);
    tick; chk_ir("br_wrap_err", 32'hC3FF_FFF1, 32'd13, 1'b0, 32'hFFFF_FFFF);
    chk_st("br_wrap_err", 1'b0, 1'b0, 1'b1);

    flush_i = 1'b1; flush_target_i = 32'd6;
    tick; chk_ir("flush6", 32'hC3FF_FFF1, 32'd13, 1'b0, 32'd6);
    chk_st("flush6", 1'b1, 1'b0, 1'b0);
    flush_i = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk_ir("async_rst", 32'd0, 32'd0, 1'b0, 32'd0);
    chk_st("async_rst", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick; chk_ir("post_rst", 32'h0111_0002, 32'd0, 1'b1, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch stage that sits directly upstream of the instruction memory.
- Drives the word address and read enable for that memory, and captures the returned word into an instruction register (IR) for the decoder.
- Resolves unconditional branches (opcode 6'b110000) locally, one cycle after fetch.
- Accepts stall from decode and redirect (flush) from execute.
- Detects the self-loop halt idiom (BR with offset -1).

Parameters:
- IMEM_DEPTH, 256, number of instruction words; valid word addresses are 0..IMEM_DEPTH-1.
- PC_RESET, 32'd0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall_i  input  1  decode cannot accept; hold PC and IR.
- flush_i  input  1  execute redirect (taken conditional branch).
- flush_target_i  input  32  word address to fetch after a flush.
- im_addr_o  output  32  word address to instruction memory; equals the PC register.
- im_read_o  output  1  read enable to instruction memory.
- im_data_i  input  32  combinational read data from instruction memory.
- ir_o  output  32  captured instruction.
- ir_pc_o  output  32  word address of ir_o.
- ir_valid_o  output  1  ir_o holds a live instruction.
- halt_o  output  1  core halted on a self-loop branch.
- pc_oob_o  output  1  PC outside 0..IMEM_DEPTH-1.

Behaviour:
- Reset (async assert, sync to clk on release):
  - pc=PC_RESET; ir_o=0; ir_pc_o=0; ir_valid_o=0; halt_o=0; pc_oob_o=0; state=RUN.
  - If PC_RESET>=IMEM_DEPTH, state=ERROR on the first edge.
- States: RUN, HALT, ERROR.
- Combinational outputs:
  - im_addr_o = pc.
  - im_read_o = 1 only in RUN with pc<IMEM_DEPTH.
  - halt_o = (state==HALT).
  - pc_oob_o = (state==ERROR).
- Per-edge priority: flush_i > stall_i > normal fetch.
- flush_i=1 (any state):
  - pc<=flush_target_i; ir_valid_o<=0; IR contents unchanged.
  - Next state is RUN if flush_target_i<IMEM_DEPTH, else ERROR.
  - Flush overrides a simultaneous stall and is the only exit from HALT or ERROR.
- RUN, stall_i=1, no flush: pc, ir_o, ir_pc_o and ir_valid_o all hold; im_read_o stays 1.
- RUN, no stall, no flush, pc<IMEM_DEPTH:
  - ir_o<=im_data_i; ir_pc_o<=pc; ir_valid_o<=1.
  - If im_data_i[31:26]==6'b110000 (unconditional BR): off = sign-extend im_data_i[25:0].
    - If off==-1: pc holds, state<=HALT. The BR is still delivered with ir_valid_o=1.
    - Else: pc<=pc+1+off.
  - Otherwise: pc<=pc+1.
  - All PC arithmetic is 32-bit modulo 2^32.
- Out of range: a next pc >= IMEM_DEPTH (including wrap to 0xFFFFFFFF) enters ERROR on the following edge, with no fetch and ir_valid_o<=0.
- HALT: no fetch; ir_valid_o<=0 on the next unstalled edge; ir_o and ir_pc_o hold.
- ERROR: ir_valid_o<=0; pc holds.
- Latency: the word at address A appears on ir_o/ir_pc_o one edge after im_addr_o==A with no stall. A local BR redirect has zero bubbles; a flush costs one bubble.
- A reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- An X value on im_data_i while im_read_o=0 must not affect state.

Test Plan:
- Release reset, memory preloaded with the gcd program (word 0 = 32'h01110002):
  - First edge: ir_o=32'h01110002, ir_pc_o=0, ir_valid_o=1, im_addr_o=1.
  - Subsequent fetches increment by 1.
- Fetch word 4 = 32'hC3FFFFFB (BR -5):
  - Next edge: ir_pc_o=4, im_addr_o=0.
  - Following edge: ir_pc_o=0; no bubble.
- Fetch word 8 = 32'hC3FFFFFF (BR -1):
  - ir_valid_o=1 for one cycle with ir_pc_o=8, then halt_o=1, im_read_o=0, im_addr_o=8.
  - flush_i with target 2 returns to RUN and the next fetch is word 2.
- Hold stall_i=1 for 3 cycles at pc=5 with a 4th-cycle flush_i to target 1:
  - ir_o/ir_pc_o/ir_valid_o frozen for 3 cycles.
  - On the flush edge, ir_valid_o=0 and im_addr_o=1.
- flush_i with target 300 (IMEM_DEPTH=256):
  - pc_oob_o=1, im_read_o=0, ir_valid_o=0.
  - flush_i with target 0 recovers.
- Assert rst_n=0 between clock edges at pc=6:
  - All outputs return to reset values immediately.
  - After release the first fetch is word 0.
